// File: rtl/lamp_demux_guard_if.sv
// rtl/lamp_demux_guard_if.sv - lamp-select bus between phase sequencer and lamp demux
interface lamp_demux_guard_if #(
    parameter int NCH = 3
);
    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;

    logic            en;
    logic [SELW-1:0] sel;
    logic [NCH-1:0]  out;
    logic [SELW-1:0] cur_sel;
    logic            active;
    logic            guard;
    logic            fault;

    modport master (
        output en, sel,
        input  out, cur_sel, active, guard, fault
    );

    modport slave (
        input  en, sel,
        output out, cur_sel, active, guard, fault
    );
endinterface

// File: rtl/lamp_demux_guard.sv
// rtl/lamp_demux_guard.sv - registered 1-to-NCH lamp demux with break-before-make guard; option macro LAMP_DEMUX_FAULT_LATCH_EN
module lamp_demux_guard #(
    parameter int NCH       = 3,
    parameter int GUARD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    lamp_demux_guard_if.slave bus
);
    localparam int             SELW       = (NCH > 2) ? $clog2(NCH) : 1;
    localparam logic [7:0]     GUARD_INIT = 8'(GUARD_CYC - 1);
    localparam logic [NCH-1:0] ONE_HOT0   = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_GUARD
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic [SELW-1:0] pend_q, pend_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NCH-1:0]  out_q, out_d;
    logic            active_q, active_d;
    logic            guard_q, guard_d;
    logic            fault_q, fault_d;
    logic            sel_valid;
    logic            bad_req;
    logic            frozen;

    assign sel_valid = (32'(bus.sel) < NCH);
    assign bad_req   = bus.en & ~sel_valid;

`ifdef LAMP_DEMUX_FAULT_LATCH_EN
    // A latched fault parks the block in OFF until reset.
    assign frozen = fault_q;
`else
    assign frozen = 1'b0;
`endif

    // Next-state and next-output decode; outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
`ifdef LAMP_DEMUX_FAULT_LATCH_EN
        fault_d   = fault_q | bad_req;
`else
        fault_d   = bad_req;
`endif

        if (frozen) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Nothing is lit, so a new channel can come on without a guard.
                    if (bus.en && sel_valid) begin
                        state_d   = ST_ON;
                        cur_sel_d = bus.sel;
                    end
                end
                ST_ON: begin
                    if (!bus.en || !sel_valid) begin
                        state_d = ST_OFF;
                    end else if (bus.sel != cur_sel_q) begin
                        state_d = ST_GUARD;
                        pend_d  = bus.sel;
                        cnt_d   = GUARD_INIT;
                    end
                end
                ST_GUARD: begin
                    if (!bus.en || !sel_valid) begin
                        state_d = ST_OFF;
                    end else begin
                        // Late select changes retarget the pending channel but never
                        // restart the guard; the newest request wins on exit.
                        pend_d = bus.sel;
                        if (cnt_q == 8'd0) begin
                            state_d   = ST_ON;
                            cur_sel_d = bus.sel;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // A fault always leaves every lamp dark.
        if (fault_d) begin
            state_d = ST_OFF;
        end

        out_d    = (state_d == ST_ON) ? (ONE_HOT0 << cur_sel_d) : '0;
        active_d = (state_d == ST_ON);
        guard_d  = (state_d == ST_GUARD);
    end

    // State and registered outputs; reset discards any pending channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            cur_sel_q <= '0;
            pend_q    <= '0;
            cnt_q     <= 8'd0;
            out_q     <= '0;
            active_q  <= 1'b0;
            guard_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            active_q  <= active_d;
            guard_q   <= guard_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.cur_sel = cur_sel_q;
    assign bus.active  = active_q;
    assign bus.guard   = guard_q;
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_lamp_demux_guard.sv
// tb/tb_lamp_demux_guard.sv - scoreboard bench for lamp_demux_guard (NCH=3, GUARD_CYC=2)
module tb_lamp_demux_guard;
    logic clk;
    logic rst_n;

    lamp_demux_guard_if #(.NCH(3)) bus ();

    lamp_demux_guard #(
        .NCH      (3),
        .GUARD_CYC(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic       en;
        logic [1:0] sel;
        logic [2:0] out;
        logic [1:0] cur;
        logic       act;
        logic       grd;
        logic       flt;
    } row_t;

    row_t sb[$];
    row_t exp_r;
    int   n_asserts = 0;
    int   n_fail    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(logic en, logic [1:0] sel, logic [2:0] out, logic [1:0] cur,
                                logic act, logic grd, logic flt);
        row_t r;
        r.en = en; r.sel = sel; r.out = out; r.cur = cur;
        r.act = act; r.grd = grd; r.flt = flt;
        return r;
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.en = 1'b1;
        bus.sel = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        n_asserts++;
        if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required all zero",
                     bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault);
        end
        @(negedge clk);
        bus.en  = 1'b0;
        bus.sel = 2'd0;
        rst_n   = 1'b1;
    endtask

    task automatic test_select_on();
        row_t rows[$];
        rows.push_back(mk(1, 0, 3'b001, 0, 1, 0, 0));
        rows.push_back(mk(1, 0, 3'b001, 0, 1, 0, 0));
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL select_on row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
        end
    endtask

    task automatic test_guard();
        row_t rows[$];
        rows.push_back(mk(1, 2, 3'b000, 0, 0, 1, 0));
        rows.push_back(mk(1, 2, 3'b000, 0, 0, 1, 0));
        rows.push_back(mk(1, 2, 3'b100, 2, 1, 0, 0));
        rows.push_back(mk(1, 2, 3'b100, 2, 1, 0, 0));
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL guard row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
            n_asserts++;
            if ($countones(bus.out) > 1 || (bus.guard && bus.active)) begin
                n_fail++;
                $display("FAIL guard_invariant row %0d: out=%b guard=%b active=%b, required popcount<=1 and not guard&active",
                         i, bus.out, bus.guard, bus.active);
            end
        end
    endtask

    task automatic test_guard_retarget();
        row_t rows[$];
        // ch2 -> ch0 request, then back to ch2 mid-guard: guard still completes
        rows.push_back(mk(1, 0, 3'b000, 2, 0, 1, 0));
        rows.push_back(mk(1, 2, 3'b000, 2, 0, 1, 0));
        rows.push_back(mk(1, 2, 3'b100, 2, 1, 0, 0));
        // ch2 -> ch0 request, retargeted to ch1 on the second guard cycle
        rows.push_back(mk(1, 0, 3'b000, 2, 0, 1, 0));
        rows.push_back(mk(1, 0, 3'b000, 2, 0, 1, 0));
        rows.push_back(mk(1, 1, 3'b010, 1, 1, 0, 0));
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL guard_retarget row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
            n_asserts++;
            if ($countones(bus.out) > 1 || (bus.guard && bus.active)) begin
                n_fail++;
                $display("FAIL retarget_invariant row %0d: out=%b guard=%b active=%b, required popcount<=1 and not guard&active",
                         i, bus.out, bus.guard, bus.active);
            end
        end
    endtask

    task automatic test_enable_drop();
        row_t rows[$];
        rows.push_back(mk(0, 1, 3'b000, 1, 0, 0, 0));
        rows.push_back(mk(1, 1, 3'b010, 1, 1, 0, 0));
        rows.push_back(mk(1, 0, 3'b000, 1, 0, 1, 0));
        rows.push_back(mk(0, 0, 3'b000, 1, 0, 0, 0));
        rows.push_back(mk(1, 0, 3'b001, 0, 1, 0, 0));
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL enable_drop row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
        end
    endtask

    task automatic test_fault();
        row_t rows[$];
        rows.push_back(mk(1, 3, 3'b000, 0, 0, 0, 1));
`ifdef LAMP_DEMUX_FAULT_LATCH_EN
        rows.push_back(mk(1, 1, 3'b000, 0, 0, 0, 1));
        rows.push_back(mk(0, 0, 3'b000, 0, 0, 0, 1));
        rows.push_back(mk(1, 2, 3'b000, 0, 0, 0, 1));
`else
        rows.push_back(mk(1, 1, 3'b010, 1, 1, 0, 0));
        rows.push_back(mk(0, 3, 3'b000, 1, 0, 0, 0));
`endif
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL fault row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
        end
`ifdef LAMP_DEMUX_FAULT_LATCH_EN
        // Only a reset pulse clears the latched fault.
        #2;
        rst_n = 1'b0;
        #1;
        n_asserts++;
        if (bus.fault !== 1'b0 || bus.out !== 3'b000) begin
            n_fail++;
            $display("FAIL fault_reset_clear: fault=%b out=%b, required fault=0 out=000", bus.fault, bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_reset_mid_guard();
        row_t rows[$];
        rows.push_back(mk(1, 0, 3'b001, 0, 1, 0, 0));
        rows.push_back(mk(1, 1, 3'b000, 0, 0, 1, 0));
        foreach (rows[i]) begin
            @(negedge clk);
            bus.en = rows[i].en; bus.sel = rows[i].sel;
            sb.push_back(rows[i]);
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            n_asserts++;
            if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
                n_fail++;
                $display("FAIL reset_mid_guard row %0d: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                         i, bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
            end
        end
        // Assert reset between edges while the guard is running.
        #2;
        rst_n = 1'b0;
        #1;
        n_asserts++;
        if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== 8'b0) begin
            n_fail++;
            $display("FAIL async_reset_mid_guard: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required all zero",
                     bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault);
        end
        @(posedge clk); #1;
        n_asserts++;
        if ({bus.out, bus.active, bus.guard} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held: out=%b active=%b guard=%b, required all zero", bus.out, bus.active, bus.guard);
        end
        @(negedge clk);
        bus.en  = 1'b1;
        bus.sel = 2'd2;
        rst_n   = 1'b1;
        sb.push_back(mk(1, 2, 3'b100, 2, 1, 0, 0));
        @(posedge clk); #1;
        exp_r = sb.pop_front();
        n_asserts++;
        if ({bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault} !== {exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt}) begin
            n_fail++;
            $display("FAIL after_reset_on: out=%b cur_sel=%0d active=%b guard=%b fault=%b, required out=%b cur_sel=%0d active=%b guard=%b fault=%b",
                     bus.out, bus.cur_sel, bus.active, bus.guard, bus.fault, exp_r.out, exp_r.cur, exp_r.act, exp_r.grd, exp_r.flt);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.sel = 2'd0;
        test_reset();
        test_select_on();
        test_guard();
        test_guard_retarget();
        test_enable_drop();
        test_fault();
        test_reset_mid_guard();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
